manhattan_update_sequencer: RTL and testbench

Sequencer that drives the Manhattan weight-update datapath from weight and error memories. On `start` it walks all weight addresses. For each one it:
- reads the old weight and its differentiated error;
- presents both, plus the latched eta, to the combinational Manhattan updater;
- captures the updated weight;
- writes the result back to the weight memory.

It sits between the training controller (start/done) and the weight/error RAMs. The Manhattan updater is its combinational slave.

---
 rtl/manhattan_update_sequencer.sv | 148 ++++++++++++++
 tb/tb_manhattan_update_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/manhattan_update_sequencer.sv
// Walks every weight address: read old weight + error, run the combinational Manhattan updater, write back.
// Latency: 4 cycles per weight, done pulse in cycle 4*NUM_WEIGHTS+1 after start acceptance.
// Backpressure: none; start is ignored while busy, and abort returns to IDLE within one cycle.
module manhattan_update_sequencer #(
    parameter int BIT_WIDTH   = 32,
    parameter int EXTRA_BIT   = 2,
    parameter int NUM_WEIGHTS = 16,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0]  eta,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0]  wt_rd_data,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0]  err_rd_data,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0]  mh_old_weight,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0]  mh_error,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0]  mh_eta,
    output logic                            mh_enable,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0]  mh_updated_weight,
    output logic                            wt_wr_en,
    output logic [ADDR_WIDTH-1:0]           wt_wr_addr,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0]  wt_wr_data,
    output logic                            busy,
    output logic                            done,
    output logic                            aborted,
    output logic [ADDR_WIDTH:0]             update_count
);

    localparam int W = BIT_WIDTH + EXTRA_BIT;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  walking;
    logic                  abort_hit;
    logic                  start_acc;
    logic                  last_addr;

    assign walking   = (state == S_READ) || (state == S_WAIT) ||
                       (state == S_UPDATE) || (state == S_WRITE);
    assign abort_hit = walking && abort;
    assign start_acc = (state == S_IDLE) && start;
    assign last_addr = (addr == LAST_ADDR);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_READ;
            S_READ:   state_nxt = S_WAIT;
            S_WAIT:   state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = S_WRITE;
            S_WRITE:  state_nxt = last_addr ? S_DONE : S_READ;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // Abort overrides any walk transition; IDLE and DONE never see it.
        if (abort_hit) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // addr stops at the last weight rather than wrapping; only a new start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (start_acc) begin
            addr <= '0;
        end else if ((state == S_WRITE) && !abort && !last_addr) begin
            addr <= addr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mh_eta <= '0;
        end else if (start_acc) begin
            mh_eta <= eta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mh_old_weight <= '0;
            mh_error      <= '0;
        end else if ((state == S_WAIT) && !abort) begin
            mh_old_weight <= wt_rd_data;
            mh_error      <= err_rd_data;
        end
    end

    // The updater output is only meaningful while mh_enable is high, i.e. in UPDATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_wr_data <= '0;
        end else if ((state == S_UPDATE) && !abort) begin
            wt_wr_data <= mh_updated_weight;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_count <= '0;
        end else if (start_acc) begin
            update_count <= '0;
        end else if ((state == S_UPDATE) && !abort && (mh_error != {W{1'b0}})) begin
            update_count <= update_count + (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort_hit;
        end
    end

    assign mem_rd_en   = (state == S_READ);
    assign mem_rd_addr = addr;
    assign mh_enable   = (state == S_UPDATE);
    // An abort landing in WRITE must kill the strobe in that same cycle.
    assign wt_wr_en    = (state == S_WRITE) && !abort;
    assign wt_wr_addr  = addr;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_manhattan_update_sequencer.sv
// Randomized bench for manhattan_update_sequencer with RAM and updater models and a per-cycle schedule model.
module tb_manhattan_update_sequencer;

    localparam int BW = 32;
    localparam int EB = 2;
    localparam int W  = BW + EB;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam int D  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  eta = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [W-1:0]  wt_rd_data;
    logic [W-1:0]  err_rd_data;
    logic [W-1:0]  mh_old_weight;
    logic [W-1:0]  mh_error;
    logic [W-1:0]  mh_eta;
    logic          mh_enable;
    logic [W-1:0]  mh_updated_weight;
    logic          wt_wr_en;
    logic [AW-1:0] wt_wr_addr;
    logic [W-1:0]  wt_wr_data;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW:0]   update_count;

    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [W-1:0]  ld_wt = '0;
    logic [W-1:0]  ld_err = '0;

    logic [W-1:0]  wt_mem [D];
    logic [W-1:0]  err_mem [D];
    logic [W-1:0]  m_wt [N];
    logic [W-1:0]  m_err [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    manhattan_update_sequencer #(
        .BIT_WIDTH(BW), .EXTRA_BIT(EB), .NUM_WEIGHTS(N), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .eta(eta),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .wt_rd_data(wt_rd_data), .err_rd_data(err_rd_data),
        .mh_old_weight(mh_old_weight), .mh_error(mh_error), .mh_eta(mh_eta),
        .mh_enable(mh_enable), .mh_updated_weight(mh_updated_weight),
        .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr), .wt_wr_data(wt_wr_data),
        .busy(busy), .done(done), .aborted(aborted), .update_count(update_count)
    );

    // Stand-in updater: sign-directed step by eta, zero error passes the weight through.
    function automatic logic [W-1:0] upd(input logic [W-1:0] o, input logic [W-1:0] er,
                                         input logic [W-1:0] et);
        if (er == '0) return o;
        return er[BW-1] ? o + et : o - et;
    endfunction

    // Poison value outside UPDATE so sampling at the wrong time shows up.
    always_comb mh_updated_weight = mh_enable ? upd(mh_old_weight, mh_error, mh_eta) : 34'h25A5AA5A5;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            wt_rd_data  <= wt_mem[mem_rd_addr];
            err_rd_data <= err_mem[mem_rd_addr];
        end
        if (ld_en) begin
            wt_mem[ld_addr]  <= ld_wt;
            err_mem[ld_addr] <= ld_err;
        end else if (wt_wr_en) begin
            wt_mem[wt_wr_addr] <= wt_wr_data;
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {2'b01, 32'($urandom)};
    endfunction

    task automatic load_mem();
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            ld_en = 1'b1; ld_addr = AW'(k); ld_wt = m_wt[k]; ld_err = m_err[k];
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic chk_zero();
        check("rst_ctrl", W'({mem_rd_en, mh_enable, wt_wr_en, busy, done, aborted}), '0);
        check("rst_addr", W'({mem_rd_addr, wt_wr_addr}), '0);
        check("rst_old", mh_old_weight, '0);
        check("rst_err", mh_error, '0);
        check("rst_eta", mh_eta, '0);
        check("rst_wdat", wt_wr_data, '0);
        check("rst_cnt", W'(update_count), '0);
    endtask

    // One pass; abort_at is the cycle number (1 = first READ) in which abort is held, 0 = never.
    task automatic run_pass(input logic [W-1:0] e, input int abort_at, input bit spam,
                            input bit wiggle, input bit abort_with_start);
        logic [W-1:0] exp_wt [N];
        int exp_cnt, a_eff, last, k, ph;
        bit act, inwalk;
        a_eff = (abort_at >= 1 && abort_at <= 4*N) ? abort_at : 0;
        exp_cnt = 0;
        for (int i = 0; i < N; i++) begin
            exp_wt[i] = m_wt[i];
            if (a_eff == 0 || 4*i+4 < a_eff) exp_wt[i] = upd(m_wt[i], m_err[i], e);
            if ((a_eff == 0 || 4*i+3 < a_eff) && m_err[i] != '0) exp_cnt++;
        end
        @(posedge clk); #1;
        start = 1'b1; eta = e; abort = abort_with_start;
        last = (a_eff != 0) ? a_eff + 1 : 4*N + 2;
        for (int j = 1; j <= last; j++) begin
            @(posedge clk); #1;
            start = spam && (j <= 4*N+1);
            abort = (j == abort_at);
            eta   = wiggle ? rnd_word() : e;
            @(negedge clk);
            act    = (a_eff != 0) ? (j <= a_eff) : (j <= 4*N+1);
            inwalk = act && (j <= 4*N);
            k  = (j - 1) / 4;
            ph = (j - 1) % 4;
            check("busy", W'(busy), W'(act));
            check("done", W'(done), W'(a_eff == 0 && j == 4*N+1));
            check("aborted", W'(aborted), W'(a_eff != 0 && j == a_eff+1));
            check("rd_en", W'(mem_rd_en), W'(inwalk && ph == 0));
            check("mh_en", W'(mh_enable), W'(inwalk && ph == 2));
            check("wr_en", W'(wt_wr_en), W'(inwalk && ph == 3 && j != a_eff));
            check("mh_eta", mh_eta, e);
            if (inwalk && ph == 0) check("rd_addr", W'(mem_rd_addr), W'(k));
            if (inwalk && ph == 2) begin
                check("mh_old", mh_old_weight, m_wt[k]);
                check("mh_err", mh_error, m_err[k]);
            end
            if (inwalk && ph == 3 && j != a_eff) begin
                check("wr_addr", W'(wt_wr_addr), W'(k));
                check("wr_data", wt_wr_data, exp_wt[k]);
            end
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("idle_busy", W'(busy), '0);
        check("idle_abt", W'(aborted), '0);
        check("upd_cnt", W'(update_count), W'(exp_cnt));
        for (int i = 0; i < N; i++) begin
            check("ram", wt_mem[i], exp_wt[i]);
            m_wt[i] = exp_wt[i];
        end
    endtask

    task automatic reset_mid(input logic [W-1:0] e);
        logic [W-1:0] exp_wt [N];
        for (int i = 0; i < N; i++)
            exp_wt[i] = (i < 2) ? upd(m_wt[i], m_err[i], e) : m_wt[i];
        @(posedge clk); #1;
        start = 1'b1; eta = e;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_upd", W'(mh_enable), W'(1));
        rst_n = 1'b0;
        #1;
        chk_zero();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            check("ram_rst", wt_mem[i], exp_wt[i]);
            m_wt[i] = exp_wt[i];
        end
    endtask

    initial begin
        int a;
        #12;
        chk_zero();
        rst_n = 1'b1;

        // abort alone in IDLE does nothing
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("idle_abort_abt", W'(aborted), '0);
        check("idle_abort_busy", W'(busy), '0);

        // weights {1,2,-1,0}, errors {+0.3,-0.2,+1.0,0}, eta 0.5
        m_wt[0] = {2'b01, 32'h3F800000}; m_err[0] = {2'b01, 32'h3E99999A};
        m_wt[1] = {2'b01, 32'h40000000}; m_err[1] = {2'b01, 32'hBE4CCCCD};
        m_wt[2] = {2'b01, 32'hBF800000}; m_err[2] = {2'b01, 32'h3F800000};
        m_wt[3] = '0;                    m_err[3] = '0;
        load_mem();
        run_pass({2'b01, 32'h3F000000}, 0, 1'b0, 1'b0, 1'b0);

        // all-zero errors
        for (int i = 0; i < N; i++) begin m_wt[i] = rnd_word(); m_err[i] = '0; end
        load_mem();
        run_pass(rnd_word(), 0, 1'b0, 1'b0, 1'b0);

        // abort in WRITE of addr 1
        for (int i = 0; i < N; i++) begin m_wt[i] = rnd_word(); m_err[i] = rnd_word(); end
        load_mem();
        run_pass(rnd_word(), 8, 1'b0, 1'b0, 1'b0);

        // start held through the busy window, then a second pass with a new eta
        run_pass(rnd_word(), 0, 1'b1, 1'b0, 1'b0);
        run_pass(rnd_word(), 0, 1'b0, 1'b0, 1'b0);

        // reset in UPDATE of addr 2, then a clean pass
        reset_mid(rnd_word());
        run_pass(rnd_word(), 0, 1'b0, 1'b0, 1'b0);

        // eta changing mid-pass; abort+start together; abort in DONE
        run_pass(rnd_word(), 0, 1'b0, 1'b1, 1'b0);
        run_pass(rnd_word(), 4*N+1, 1'b0, 1'b0, 1'b1);

        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < N; i++) begin
                m_wt[i]  = rnd_word();
                m_err[i] = ($urandom_range(0, 3) == 0) ? '0 : rnd_word();
            end
            load_mem();
            a = 0;
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(1, 4*N);
                if ((a - 1) % 4 == 2) a++;
            end
            run_pass(rnd_word(), a, 1'b0, $urandom_range(0, 1) == 1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
